// File: rtl/kgprisc_pkg.sv
// Shared KGPRISC definitions: branch condition codes, branch FSM states
// and the sequential fetch increment.
package kgprisc_pkg;

    localparam logic [2:0] COND_NEVER   = 3'b000;
    localparam logic [2:0] COND_ALWAYS  = 3'b001;
    localparam logic [2:0] COND_SIGN    = 3'b010;
    localparam logic [2:0] COND_ZERO    = 3'b011;
    localparam logic [2:0] COND_NZERO   = 3'b100;
    localparam logic [2:0] COND_CARRY   = 3'b101;
    localparam logic [2:0] COND_NCARRY  = 3'b110;
    localparam logic [2:0] COND_CALL    = 3'b111;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bsq_state_e;

endpackage

// File: rtl/branch_sequencer_if.sv
// Bundle between the core (ALU flags, decoded branch) and the branch
// sequencer (PC, flush, link write, architectural flags).
interface branch_sequencer_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic            alu_wr;
    logic [31:0]     alu_sum;
    logic            alu_carry;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            taken;
    logic            link_we;
    logic [PC_W-1:0] link_pc;
    logic            flag_c;
    logic            flag_z;
    logic            flag_s;

    modport master (
        output stall, alu_wr, alu_sum, alu_carry, br_valid, br_cond, br_target,
        input  pc, flush, taken, link_we, link_pc, flag_c, flag_z, flag_s
    );

    modport slave (
        input  stall, alu_wr, alu_sum, alu_carry, br_valid, br_cond, br_target,
        output pc, flush, taken, link_we, link_pc, flag_c, flag_z, flag_s
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: decides whether a condition
// code is satisfied by a given set of carry/zero/sign flags.
module branch_cond
    import kgprisc_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic       i_c,
    input  logic       i_z,
    input  logic       i_s,
    output logic       o_take
);

    // Condition decode
    always_comb begin
        o_take = 1'b0;
        case (i_cond)
            COND_NEVER:  o_take = 1'b0;
            COND_ALWAYS: o_take = 1'b1;
            COND_SIGN:   o_take = i_s;
            COND_ZERO:   o_take = i_z;
            COND_NZERO:  o_take = ~i_z;
            COND_CARRY:  o_take = i_c;
            COND_NCARRY: o_take = ~i_c;
            COND_CALL:   o_take = 1'b1;
            default:     o_take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer: architectural flag register with same-cycle forwarding,
// RUN/FLUSH control FSM, program counter and call link registers.
module branch_sequencer
    import kgprisc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    branch_sequencer_if.slave   bus
);

    bsq_state_e      r_state;
    bsq_state_e      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic            r_flush;
    logic            r_taken;
    logic            r_link_we;
    logic [PC_W-1:0] r_link_pc;
    logic            r_flag_c;
    logic            r_flag_z;
    logic            r_flag_s;

    logic            w_in_c;
    logic            w_in_z;
    logic            w_in_s;
    logic            w_ev_c;
    logic            w_ev_z;
    logic            w_ev_s;
    logic            w_cond_ok;
    logic            w_run_go;
    logic            w_take;
    logic [PC_W-1:0] w_pc_inc;

    logic [PC_W-1:0] w_pc_nxt;
    logic            w_flush_nxt;
    logic            w_taken_nxt;
    logic            w_link_we_nxt;
    logic [PC_W-1:0] w_link_pc_nxt;
    logic            w_flag_c_nxt;
    logic            w_flag_z_nxt;
    logic            w_flag_s_nxt;

    assign w_in_c   = bus.alu_carry;
    assign w_in_z   = (bus.alu_sum == 32'd0);
    assign w_in_s   = bus.alu_sum[31];
    assign w_pc_inc = r_pc + PC_W'(PC_INC);
    assign w_run_go = (r_state == ST_RUN) && !bus.stall;

    // A branch paired with an ALU write sees the flags it is about to produce
    always_comb begin
        if (bus.alu_wr) begin
            w_ev_c = w_in_c;
            w_ev_z = w_in_z;
            w_ev_s = w_in_s;
        end else begin
            w_ev_c = r_flag_c;
            w_ev_z = r_flag_z;
            w_ev_s = r_flag_s;
        end
    end

    branch_cond u_cond (
        .i_cond (bus.br_cond),
        .i_c    (w_ev_c),
        .i_z    (w_ev_z),
        .i_s    (w_ev_s),
        .o_take (w_cond_ok)
    );

    assign w_take = w_run_go && bus.br_valid && w_cond_ok;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   w_state_nxt = w_take ? ST_FLUSH : ST_RUN;
            ST_FLUSH: w_state_nxt = bus.stall ? ST_FLUSH : ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Next values for PC, link, flush and flag registers
    always_comb begin
        w_pc_nxt      = r_pc;
        w_taken_nxt   = r_taken;
        w_link_we_nxt = 1'b0;
        w_link_pc_nxt = r_link_pc;
        w_flag_c_nxt  = r_flag_c;
        w_flag_z_nxt  = r_flag_z;
        w_flag_s_nxt  = r_flag_s;
        w_flush_nxt   = (w_state_nxt == ST_FLUSH);
        case (r_state)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.alu_wr) begin
                        w_flag_c_nxt = w_in_c;
                        w_flag_z_nxt = w_in_z;
                        w_flag_s_nxt = w_in_s;
                    end else begin
                        w_flag_c_nxt = r_flag_c;
                    end
                    if (w_take) begin
                        w_pc_nxt    = bus.br_target;
                        w_taken_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                        if (bus.br_valid) begin
                            w_taken_nxt = 1'b0;
                        end else begin
                            w_taken_nxt = r_taken;
                        end
                    end
                    if (w_take && (bus.br_cond == COND_CALL)) begin
                        w_link_we_nxt = 1'b1;
                        w_link_pc_nxt = w_pc_inc;
                    end else begin
                        w_link_we_nxt = 1'b0;
                    end
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_FLUSH: begin
                // The instruction in the shadow of the branch is squashed
                if (!bus.stall) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_flush   <= 1'b0;
            r_taken   <= 1'b0;
            r_link_we <= 1'b0;
            r_link_pc <= '0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_s  <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_flush   <= w_flush_nxt;
            r_taken   <= w_taken_nxt;
            r_link_we <= w_link_we_nxt;
            r_link_pc <= w_link_pc_nxt;
            r_flag_c  <= w_flag_c_nxt;
            r_flag_z  <= w_flag_z_nxt;
            r_flag_s  <= w_flag_s_nxt;
        end
    end

    assign bus.pc      = r_pc;
    assign bus.flush   = r_flush;
    assign bus.taken   = r_taken;
    assign bus.link_we = r_link_we;
    assign bus.link_pc = r_link_pc;
    assign bus.flag_c  = r_flag_c;
    assign bus.flag_z  = r_flag_z;
    assign bus.flag_s  = r_flag_s;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;
    import kgprisc_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    branch_sequencer_if #(.PC_W(32)) bus ();

    branch_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic st, input logic aw, input logic [31:0] sum,
                         input logic cy, input logic bv, input logic [2:0] cond,
                         input logic [31:0] tgt);
        bus.stall     = st;
        bus.alu_wr    = aw;
        bus.alu_sum   = sum;
        bus.alu_carry = cy;
        bus.br_valid  = bv;
        bus.br_cond   = cond;
        bus.br_target = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {pc, flush, taken, link_we}
    task automatic chk_pc(input string name, input logic [31:0] pc_e, input logic fl_e,
                          input logic tk_e, input logic lw_e);
        total++;
        if ({bus.pc, bus.flush, bus.taken, bus.link_we} !== {pc_e, fl_e, tk_e, lw_e}) begin
            bad++;
            $display("FAIL %s: pc/flush/taken/link_we got %h/%b/%b/%b want %h/%b/%b/%b",
                     name, bus.pc, bus.flush, bus.taken, bus.link_we, pc_e, fl_e, tk_e, lw_e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #3;
        total++;
        if ({bus.pc, bus.flush, bus.taken, bus.link_we, bus.link_pc, bus.flag_c, bus.flag_z, bus.flag_s}
            !== {32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000}) begin
            bad++;
            $display("FAIL reset_init: pc=%h flush=%b want pc=0 flush=0", bus.pc, bus.flush);
        end
        @(posedge clk); #1; rst = 1'b1;
        step(); chk_pc("rel_pc4", 32'h4, 1'b0, 1'b0, 1'b0);
        step(); chk_pc("rel_pc8", 32'h8, 1'b0, 1'b0, 1'b0);
        // get into FLUSH at 0x40 with nonzero flags
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, COND_ALWAYS, 32'h40);
        step(); idle();
        chk_pc("to_0x40", 32'h40, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        total++;
        if ({bus.pc, bus.flush, bus.taken, bus.flag_c, bus.flag_z, bus.flag_s}
            !== {32'h0, 1'b0, 1'b0, 3'b000}) begin
            bad++;
            $display("FAIL reset_mid_flush: pc=%h flush=%b taken=%b czs=%b%b%b want 0/0/0/000",
                     bus.pc, bus.flush, bus.taken, bus.flag_c, bus.flag_z, bus.flag_s);
        end
        @(posedge clk); #1; rst = 1'b1;
        step(); chk_pc("post_rst_4", 32'h4, 1'b0, 1'b0, 1'b0);
        step(); chk_pc("post_rst_8", 32'h8, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flags();
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'b000, 32'h0);
        step(); idle();
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_s, bus.pc} !== {3'b001, 32'hC}) begin
            bad++;
            $display("FAIL flags_neg: czs=%b%b%b pc=%h want 001 0000000c",
                     bus.flag_c, bus.flag_z, bus.flag_s, bus.pc);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_SIGN, 32'h100);
        step(); idle();
        chk_pc("sign_taken", 32'h100, 1'b1, 1'b1, 1'b0);
        step();
        chk_pc("sign_flush_end", 32'h104, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_ZERO, 32'h300);
        step(); idle();
        chk_pc("zero_not_taken", 32'h108, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_forward();
        drive(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, COND_ZERO, 32'h80);
        step(); idle();
        chk_pc("fwd_zero_taken", 32'h80, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 3'b000, 32'h0);
        step(); idle();
        total++;
        if ({bus.flag_z, bus.pc} !== {1'b0, 32'h88}) begin
            bad++;
            $display("FAIL fwd_setup: z=%b pc=%h want 0 00000088", bus.flag_z, bus.pc);
        end
        drive(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, COND_NZERO, 32'h80);
        step(); idle();
        chk_pc("fwd_nz_not_taken", 32'h8C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_carry();
        drive(1'b0, 1'b1, 32'd1, 1'b1, 1'b0, 3'b000, 32'h0);
        step(); idle();
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_s} !== 3'b100) begin
            bad++;
            $display("FAIL carry_set: czs=%b%b%b want 100", bus.flag_c, bus.flag_z, bus.flag_s);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_CARRY, 32'h400);
        step(); idle();
        chk_pc("c_taken", 32'h400, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_NCARRY, 32'h500);
        step(); idle();
        chk_pc("nc_not_taken", 32'h408, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 3'b000, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_CARRY, 32'h500);
        step(); idle();
        chk_pc("c_clear_not_taken", 32'h410, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_NCARRY, 32'h600);
        step(); idle();
        chk_pc("nc_taken", 32'h600, 1'b1, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_call();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_ALWAYS, 32'h1C);
        step(); idle();
        step();
        chk_pc("call_setup", 32'h20, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_CALL, 32'h200);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_ALWAYS, 32'h900);
        chk_pc("call_taken", 32'h200, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.link_pc !== 32'h24) begin
            bad++;
            $display("FAIL call_link_pc: got %h want 00000024", bus.link_pc);
        end
        step(); idle();
        chk_pc("call_squash", 32'h204, 1'b0, 1'b1, 1'b0);
        step();
        total++;
        if ({bus.pc, bus.link_pc} !== {32'h208, 32'h24}) begin
            bad++;
            $display("FAIL call_after: pc=%h link_pc=%h want 00000208 00000024", bus.pc, bus.link_pc);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 32'd0, 1'b1, 1'b1, COND_ALWAYS, 32'h700);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.pc, bus.flush, bus.link_we, bus.flag_c, bus.flag_z, bus.flag_s}
                !== {32'h208, 1'b0, 1'b0, 3'b000}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: pc=%h czs=%b%b%b want 00000208 000",
                         i, bus.pc, bus.flag_c, bus.flag_z, bus.flag_s);
            end
        end
        idle();
        step();
        chk_pc("stall_release", 32'h20C, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_ALWAYS, 32'hFFFF_FFF8);
        step(); idle();
        step();
        chk_pc("wrap_pre", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        step();
        chk_pc("wrap_zero", 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_ALWAYS, 32'h10);
        step();
        chk_pc("b2b_first", 32'h10, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_ALWAYS, 32'h30);
        chk_pc("b2b_squash", 32'h14, 1'b0, 1'b1, 1'b0);
        step(); idle();
        chk_pc("b2b_second", 32'h30, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, COND_NEVER, 32'h99);
        step(); idle();
        chk_pc("never", 32'h38, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_flags();
        test_forward();
        test_carry();
        test_call();
        test_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Branch-side consumer of the ALU condition flags in the KGPRISC core. Latches carry/zero/sign from ALU results into an architectural flag register, evaluates the 3-bit branch condition code against those flags, and owns the program counter. It issues PC updates, a one-cycle flush on taken branches, and a link write for calls. It sits between the ALU/flag logic and instruction fetch.

## Interface
- PC_W, 32, program counter width
- RESET_PC, 0, PC value on reset
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  hold PC and state this cycle
- alu_wr  input  1  ALU result valid; update flags this cycle
- alu_sum  input  32  signed ALU result
- alu_carry  input  1  ALU carry-out
- br_valid  input  1  branch instruction present this cycle
- br_cond  input  3  condition code
- br_target  input  PC_W  absolute target address
- pc  output  PC_W  current fetch PC
- flush  output  1  squash the instruction fetched after a taken branch
- taken  output  1  registered: last resolved branch was taken
- link_we  output  1  write link_pc to link register
- link_pc  output  PC_W  return address (pc+4 of the call)
- flag_c, flag_z, flag_s  output  1 each  architectural carry/zero/sign

## Operation
- Condition codes: 000 never; 001 always; 010 sign (S=1); 011 zero (Z=1); 100 not-zero (Z=0); 101 carry (C=1); 110 no-carry (C=0); 111 call (always, with link).
- Flag update on alu_wr: C<=alu_carry, Z<=(alu_sum==0), S<=alu_sum[31]. Flags otherwise hold.
- Forwarding: if alu_wr and br_valid in the same cycle, the branch evaluates against the incoming flags, not the registered ones.
- States: RUN, FLUSH.
- RUN, stall=1: pc, flags, state hold. flush=0, link_we=0. alu_wr is ignored while stalled.
- RUN, no taken branch: pc<=pc+4.
- RUN, taken branch: pc<=br_target, taken<=1, flush<=1, next state FLUSH.
- RUN, call (111): additionally link_we<=1 and link_pc<=pc+4 on the same edge.
- RUN, branch not taken (br_valid=1): taken<=0, pc<=pc+4.
- FLUSH: flush deasserts at the next edge and pc<=pc+4. A br_valid seen in FLUSH is squashed (not evaluated), and alu_wr is ignored. Return to RUN. Stall holds FLUSH.
- Arithmetic: pc+4 wraps modulo 2^PC_W. br_target is used unchanged; no alignment check.
- Reset, including mid-FLUSH: pc=RESET_PC, state RUN, flush=0, taken=0, link_we=0, link_pc=0, flags=0.

## Timing
- All outputs registered. The PC update is visible one cycle after the evaluating edge.
- flush is high for exactly one cycle per taken branch. link_we is high for exactly one cycle per call.
- Maximum branch throughput: one taken branch every 2 cycles. Not-taken branches: 1 per cycle.
- First edge after rst deasserts: normal RUN behaviour.

## Structure
- Shared package kgprisc_pkg: cond-code localparams (COND_NEVER … COND_CALL), state enum, PC increment constant 4.
- Sub-module branch_cond: combinational; inputs cond, C, Z, S; output take. Also reused by any future predictor.
- Top holds the flag register, forwarding mux, FSM, PC and link registers.

## Test plan
- Reset: rst low mid-FLUSH with pc=0x40 -> pc=0, flush=0, flags=0 immediately; after release, pc advances 0 -> 4 -> 8.
- Flags: alu_wr with sum=-1, carry=0 -> S=1, Z=0, C=0. Then cond 010 with target 0x100 -> pc=0x100, flush high 1 cycle. Cond 011 -> not taken, pc+4.
- Forwarding: same cycle alu_wr sum=0 and br cond 011, target 0x80, registered Z=0 -> taken to 0x80. Cond 100 in the same setup -> not taken.
- Carry: alu_wr carry=1, then cond 101 -> taken; cond 110 -> not taken. Reverse with carry=0.
- Call: pc=0x20, cond 111, target 0x200 -> pc=0x200, link_we=1 for 1 cycle, link_pc=0x24. A br_valid in the FLUSH cycle is ignored.
- Stall/wrap: stall held 3 cycles -> pc, flags unchanged. pc=0xFFFFFFFC, no branch -> pc=0.
